// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: opcodes, datapath widths and NZCV flag ordering.
// Used by the ALU and by the writeback stage that follows it.
package alu_defs_pkg;

    localparam int ALU_DATA_WIDTH     = 32;
    localparam int ALU_REG_ADDR_WIDTH = 5;
    localparam int ALU_CTRL_WIDTH     = 3;
    localparam int ALU_NFLAGS         = 4;

    typedef enum logic [ALU_CTRL_WIDTH-1:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SRL = 3'b110,
        OP_SLL = 3'b111
    } alu_op_e;

    // Bit positions inside the {N,Z,C,V} status word
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [ALU_NFLAGS-1:0] pack_flags(
        input logic n,
        input logic z,
        input logic c,
        input logic v
    );
        return {n, z, c, v};
    endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// Two-entry valid/ready skid buffer over a packed word, FIFO ordered.
// in_ready depends only on registered state and reset, never on out_ready.
module wb_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_main_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_accept;
    logic             w_retire;

    assign in_ready  = ~r_skid_valid & ~reset;
    assign out_valid = r_main_valid;
    assign out_data  = r_main;
    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_retire  = r_main_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_retire) begin
            // Skid full implies in_ready=0, so no accept can coincide
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main <= in_data;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid) begin
                r_main       <= in_data;
                r_main_valid <= 1'b1;
            end else begin
                r_skid       <= in_data;
                r_skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: skid-buffered result, regfile write enable,
// forwarding outputs and the architectural NZCV status register.
module alu_writeback_stage #(
    parameter int DATA_WIDTH     = alu_defs_pkg::ALU_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = alu_defs_pkg::ALU_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic                      in_Z,
    input  logic                      in_V,
    input  logic                      in_C,
    input  logic                      in_N,
    input  logic [2:0]                in_control,
    input  logic [REG_ADDR_WIDTH-1:0] in_dest,
    input  logic                      in_set_flags,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic [REG_ADDR_WIDTH-1:0] out_dest,
    output logic                      out_write_en,
    output logic                      fwd_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd_dest,
    output logic [DATA_WIDTH-1:0]     fwd_result,
    output logic [3:0]                flags_q
);

    import alu_defs_pkg::*;

    localparam int EW = DATA_WIDTH + ALU_NFLAGS + ALU_CTRL_WIDTH
                      + REG_ADDR_WIDTH + 1;

    logic [EW-1:0]             w_in_entry;
    logic [EW-1:0]             w_out_entry;
    logic [DATA_WIDTH-1:0]     w_head_result;
    logic [ALU_NFLAGS-1:0]     w_head_flags;
    logic [ALU_CTRL_WIDTH-1:0] w_head_ctrl;
    logic [REG_ADDR_WIDTH-1:0] w_head_dest;
    logic                      w_head_sf;
    logic                      w_head_nop;
    logic                      w_retire;
    logic                      w_write_en;
    logic [ALU_NFLAGS-1:0]     r_flags;

    assign w_in_entry = {in_result,
                         pack_flags(in_N, in_Z, in_C, in_V),
                         in_control, in_dest, in_set_flags};

    wb_skid_buffer #(
        .WIDTH(EW)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (w_in_entry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (w_out_entry)
    );

    assign {w_head_result, w_head_flags, w_head_ctrl,
            w_head_dest, w_head_sf} = w_out_entry;

    assign w_head_nop = (alu_op_e'(w_head_ctrl) == OP_NOP);
    assign w_retire   = out_valid & out_ready & ~flush;
    assign w_write_en = out_valid & ~w_head_nop & (w_head_dest != '0);

    assign out_result   = w_head_result;
    assign out_dest     = w_head_dest;
    assign out_write_en = w_write_en;
    assign fwd_valid    = w_write_en;
    assign fwd_dest     = w_head_dest;
    assign fwd_result   = w_head_result;
    assign flags_q      = r_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
        end else if (w_retire && w_head_sf && !w_head_nop) begin
            r_flags <= w_head_flags;
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed, table-driven bench for alu_writeback_stage.
// Vectors carry hand-computed write-enable and cumulative NZCV values.
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_Z, in_V, in_C, in_N;
    logic [2:0]  in_control;
    logic [4:0]  in_dest;
    logic        in_set_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic        out_write_en;
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_result;
    logic [3:0]  flags_q;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_writeback_stage dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_Z        (in_Z),
        .in_V        (in_V),
        .in_C        (in_C),
        .in_N        (in_N),
        .in_control  (in_control),
        .in_dest     (in_dest),
        .in_set_flags(in_set_flags),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_dest    (out_dest),
        .out_write_en(out_write_en),
        .fwd_valid   (fwd_valid),
        .fwd_dest    (fwd_dest),
        .fwd_result  (fwd_result),
        .flags_q     (flags_q)
    );

    typedef struct {
        logic [31:0] result;
        logic [3:0]  nzcv;
        logic [2:0]  ctrl;
        logic [4:0]  dest;
        logic        sf;
        logic        exp_we;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] r,
                         input logic [3:0] f, input logic [2:0] c,
                         input logic [4:0] d, input logic sf);
        in_valid     = v;
        in_result    = r;
        {in_N, in_Z, in_C, in_V} = f;
        in_control   = c;
        in_dest      = d;
        in_set_flags = sf;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] cur_flags;

        // result, nzcv, ctrl, dest, sf, exp_we, exp_flags (cumulative)
        vecs[0] = '{32'h0000_0000, 4'b0110, 3'b001, 5'd3,  1'b1, 1'b1, 4'b0110};
        vecs[1] = '{32'h0000_1234, 4'b1001, 3'b000, 5'd5,  1'b1, 1'b0, 4'b0110};
        vecs[2] = '{32'hFFFF_FFFF, 4'b1001, 3'b010, 5'd0,  1'b1, 1'b0, 4'b1001};
        vecs[3] = '{32'h0000_0000, 4'b0100, 3'b011, 5'd7,  1'b0, 1'b1, 4'b1001};
        vecs[4] = '{32'hDEAD_BEEF, 4'b1000, 3'b100, 5'd31, 1'b1, 1'b1, 4'b1000};
        vecs[5] = '{32'h8000_0000, 4'b1010, 3'b111, 5'd1,  1'b1, 1'b1, 4'b1010};

        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_5555, 4'b1111, 3'b001, 5'd9, 1'b1);

        // Reset held two cycles with in_valid high
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_flags", flags_q, 0);
            chk("rst_out_result", out_result, 0);
            chk("rst_out_we", out_write_en, 0);
        end
        reset = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 0);
        #1;
        chk("rel_in_ready", in_ready, 1);

        // Single-entry vectors, out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].result, vecs[i].nzcv, vecs[i].ctrl,
                  vecs[i].dest, vecs[i].sf);
            step();
            drive(1'b0, 0, 0, 0, 0, 0);
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_result", i), out_result, vecs[i].result);
            chk($sformatf("v%0d_dest", i), out_dest, vecs[i].dest);
            chk($sformatf("v%0d_we", i), out_write_en, vecs[i].exp_we);
            chk($sformatf("v%0d_fwd_valid", i), fwd_valid, vecs[i].exp_we);
            chk($sformatf("v%0d_fwd_dest", i), fwd_dest, vecs[i].dest);
            chk($sformatf("v%0d_fwd_result", i), fwd_result, vecs[i].result);
            step();
            chk($sformatf("v%0d_flags", i), flags_q, vecs[i].exp_flags);
            chk($sformatf("v%0d_drained", i), out_valid, 0);
        end
        cur_flags = vecs[5].exp_flags;

        // Backpressure: A into main, B into skid, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 4'b0000, 3'b001, 5'd1, 1'b0);
        step();
        chk("bp_a_valid", out_valid, 1);
        chk("bp_a_ready", in_ready, 1);
        drive(1'b1, 32'h22, 4'b0000, 3'b001, 5'd2, 1'b0);
        step();
        drive(1'b0, 0, 0, 0, 0, 0);
        chk("bp_full_ready", in_ready, 0);
        chk("bp_hold_result", out_result, 32'h11);
        step();
        chk("bp_stable_result", out_result, 32'h11);
        chk("bp_stable_dest", out_dest, 1);
        out_ready = 1'b1;
        step();
        chk("bp_b_valid", out_valid, 1);
        chk("bp_b_result", out_result, 32'h22);
        chk("bp_b_dest", out_dest, 2);
        chk("bp_release_ready", in_ready, 1);
        step();
        chk("bp_empty", out_valid, 0);
        chk("bp_flags", flags_q, cur_flags);

        // Flush: head A has set_flags and out_ready is high during flush
        out_ready = 1'b0;
        drive(1'b1, 32'h33, 4'b0001, 3'b010, 5'd4, 1'b1);
        step();
        drive(1'b1, 32'h44, 4'b0001, 3'b010, 5'd6, 1'b1);
        step();
        chk("fl_full_ready", in_ready, 0);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h55, 4'b1111, 3'b001, 5'd8, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 0);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_flags", flags_q, cur_flags);
        step();
        chk("fl_no_c", out_valid, 0);
        chk("fl_flags2", flags_q, cur_flags);

        // Streaming: 8 back-to-back entries, out_ready held high
        drive(1'b1, 32'h100, 4'b0000, 3'b101, 5'd1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("st%0d_valid", i), out_valid, 1);
            chk($sformatf("st%0d_result", i), out_result, 32'h100 + i);
            chk($sformatf("st%0d_ready", i), in_ready, 1);
            if (i < 7)
                drive(1'b1, 32'h100 + i + 1, 4'b0000, 3'b101,
                      5'(i + 2), 1'b0);
            else
                drive(1'b0, 0, 0, 0, 0, 0);
        end
        step();
        chk("st_end", out_valid, 0);

        // Reset mid-operation discards both entries
        out_ready = 1'b0;
        drive(1'b1, 32'h66, 4'b0000, 3'b001, 5'd3, 1'b0);
        step();
        step();
        drive(1'b0, 0, 0, 0, 0, 0);
        chk("mr_full", in_ready, 0);
        reset = 1'b1;
        step();
        chk("mr_out_valid", out_valid, 0);
        chk("mr_in_ready", in_ready, 0);
        chk("mr_flags", flags_q, 0);
        chk("mr_result", out_result, 0);
        reset = 1'b0;
        step();
        chk("mr_after_valid", out_valid, 0);
        chk("mr_after_ready", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
